// File: rtl/addsub_pkg.sv
// Shared definitions for the two-requester add/subtract sequencer:
// datapath widths, operation encoding, response-stage state and the response record.
package addsub_pkg;

  localparam int WIDTH = 15;
  localparam int CNT_W = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] sum;
    logic             ovf;
  } rsp_t;

endpackage

// File: rtl/addsub15.sv
// Combinational ripple-carry add/subtract with signed overflow.
// Subtraction inverts B and injects the carry-in, so one adder serves both ops.
module addsub15
  import addsub_pkg::*;
#(
  parameter int W = addsub_pkg::WIDTH
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         op,
  output logic [W-1:0] S,
  output logic         V
);

  logic [W:0]   carry;
  logic [W-1:0] b_x;

  assign carry[0] = op;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign b_x[gi]        = B[gi] ^ op;
      assign S[gi]          = A[gi] ^ b_x[gi] ^ carry[gi];
      assign carry[gi+1]    = (A[gi] & b_x[gi]) | (A[gi] & carry[gi]) | (b_x[gi] & carry[gi]);
    end
  endgenerate

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign V = carry[W-1] ^ carry[W];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/subtract datapath between two requesters,
// with a single-entry response stage and a saturating overflow event counter.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = addsub_pkg::WIDTH,
  parameter int CNT_W = addsub_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_ovf,

  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  rsp_state_e       state_q, state_d;
  rsp_t             rsp_q, rsp_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic             acc_en;
  logic             both_valid;
  logic             grant;
  logic             accept;

  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_op;
  logic [WIDTH-1:0] dp_sum;
  logic             dp_ovf;

  // Arbitration: the draining consumer frees the stage in the same cycle.
  always_comb begin
    acc_en     = (state_q == RSP_EMPTY) || rsp_ready;
    both_valid = req0_valid && req1_valid;
    grant      = both_valid ? prio_q : req1_valid;
    accept     = acc_en && (req0_valid || req1_valid);
  end

  always_comb begin
    sel_a  = grant ? req1_a  : req0_a;
    sel_b  = grant ? req1_b  : req0_b;
    sel_op = grant ? req1_op : req0_op;
  end

  addsub15 #(
    .W (WIDTH)
  ) u_addsub (
    .A  (sel_a),
    .B  (sel_b),
    .op (sel_op),
    .S  (dp_sum),
    .V  (dp_ovf)
  );

  // Response-stage state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RSP_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Response-stage next state
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = RSP_FULL;
    end else if (state_q == RSP_FULL && rsp_ready) begin
      state_d = RSP_EMPTY;
    end
  end

  // Response-stage outputs
  always_comb begin
    rsp_valid  = (state_q == RSP_FULL);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
  end

  always_comb begin
    rsp_d  = rsp_q;
    prio_d = prio_q;
    if (accept) begin
      rsp_d.id  = grant;
      rsp_d.sum = dp_sum;
      rsp_d.ovf = dp_ovf;
      if (both_valid) begin
        prio_d = !grant;
      end
    end
  end

  // Clear wins over a simultaneous overflow acceptance.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (accept && dp_ovf && (ovf_cnt_q != {CNT_W{1'b1}})) begin
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q     <= '0;
      prio_q    <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      rsp_q     <= rsp_d;
      prio_q    <= prio_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign rsp_id    = rsp_q.id;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_ovf   = rsp_q.ovf;
  assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: handshake, arithmetic corners, round-robin,
// back-pressure, counter saturation/clear and asynchronous reset.
module tb_addsub_arbiter;

  localparam int W = 15;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_op, req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic [W-1:0] rsp_sum;
  logic         ovf_clr;
  logic [C-1:0] ovf_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_ovf    (rsp_ovf),
    .ovf_clr    (ovf_clr),
    .ovf_count  (ovf_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
    rsp_ready  = 1'b0;
    ovf_clr    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_sum",   rsp_sum,   0);
    check("rst_ovf",   rsp_ovf,   0);
    check("rst_id",    rsp_id,    0);
    check("rst_cnt",   ovf_count, 0);
    rst_n = 1'b1;

    // 5 - 3 from requester 0
    tick();
    req0_valid = 1'b1; req0_a = 15'd5; req0_b = 15'd3; req0_op = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    check("sub_r0_ready", req0_ready, 1);
    check("sub_r1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("sub_valid", rsp_valid, 1);
    check("sub_sum",   rsp_sum,   2);
    check("sub_ovf",   rsp_ovf,   0);
    check("sub_id",    rsp_id,    0);

    // Positive overflow: 0x3FFF + 1
    tick();
    req1_valid = 1'b1; req1_a = 15'h3FFF; req1_b = 15'd1; req1_op = 1'b0;
    @(negedge clk);
    check("povf_r1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    check("povf_sum", rsp_sum,   15'h4000);
    check("povf_ovf", rsp_ovf,   1);
    check("povf_id",  rsp_id,    1);
    check("povf_cnt", ovf_count, 1);

    // Negative overflow: -16384 - 1
    tick();
    req1_valid = 1'b1; req1_a = 15'h4000; req1_b = 15'd1; req1_op = 1'b1;
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    check("novf_sum", rsp_sum,   15'h3FFF);
    check("novf_ovf", rsp_ovf,   1);
    check("novf_cnt", ovf_count, 2);

    // Continuous contention: grants 0,1,0,1 (10+1=11, 20-5=15)
    tick();
    req0_valid = 1'b1; req0_a = 15'd10; req0_b = 15'd1; req0_op = 1'b0;
    req1_valid = 1'b1; req1_a = 15'd20; req1_b = 15'd5; req1_op = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rr%0d_r0_ready", i), req0_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_r1_ready", i), req1_ready, (i % 2 == 1) ? 1 : 0);
      if (i > 0) begin
        check($sformatf("rr%0d_id", i),  rsp_id,  (i - 1) % 2);
        check($sformatf("rr%0d_sum", i), rsp_sum, ((i - 1) % 2 == 1) ? 15 : 11);
      end
      tick();
    end
    // Back-pressure with requester 0 waiting; its operands wiggle meanwhile
    req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 15'd100; req0_b = 15'd50; req0_op = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_r0_ready", k), req0_ready, 0);
      check($sformatf("hold%0d_r1_ready", k), req1_ready, 0);
      check($sformatf("hold%0d_valid", k),    rsp_valid,  1);
      check($sformatf("hold%0d_id", k),       rsp_id,     1);
      check($sformatf("hold%0d_sum", k),      rsp_sum,    15);
      tick();
      req0_a = 15'(7 * k + 3);
    end
    req0_a = 15'd100; rsp_ready = 1'b1;
    @(negedge clk);
    check("release_r0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("reload_valid", rsp_valid, 1);
    check("reload_sum",   rsp_sum,   150);
    check("reload_id",    rsp_id,    0);
    tick();
    @(negedge clk);
    check("drain_valid", rsp_valid, 0);
    check("drain_sum",   rsp_sum,   150);

    // 300 overflowing operations saturate the counter
    tick();
    req0_valid = 1'b1; req0_a = 15'h3FFF; req0_b = 15'd1; req0_op = 1'b0;
    repeat (300) tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("sat_cnt", ovf_count, 255);
    tick();
    req0_valid = 1'b1; ovf_clr = 1'b1;
    tick();
    req0_valid = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    check("clr_cnt", ovf_count, 0);
    tick();
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("post_clr_cnt", ovf_count, 1);

    // One contention grant (to 0) moves prio to 1, then hold FULL and reset
    tick();
    req0_valid = 1'b1; req0_a = 15'd1; req0_b = 15'd1; req0_op = 1'b0;
    req1_valid = 1'b1;
    @(negedge clk);
    check("pre_rst_r0_ready", req0_ready, 1);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid",    rsp_valid,  1);
    check("pre_rst_sum",      rsp_sum,    2);
    check("pre_rst_r0_ready", req0_ready, 0);
    check("pre_rst_r1_ready", req1_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", rsp_valid, 0);
    check("arst_sum",   rsp_sum,   0);
    check("arst_id",    rsp_id,    0);
    check("arst_cnt",   ovf_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_r0_ready", req0_ready, 1);
    check("post_rst_r1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("post_rst_id", rsp_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Sequencer and arbiter that shares one 15-bit two's-complement add/subtract datapath between two independent requesters. Each requester presents operands and an operation code over a valid/ready handshake. The block grants the datapath round-robin and registers sum, signed-overflow flag and requester ID into a single-entry response stage with its own valid/ready handshake. It sits between the operand-producing units and the result consumer, and also keeps a saturating overflow event counter for status readout.

## Interface
- WIDTH, 15, operand/result width; fixed by the shared datapath.
- CNT_W, 8, width of the overflow event counter.

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_a, req0_b  in  WIDTH  signed operands.
- req0_op  in  1  0 = A+B, 1 = A−B.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same definitions for requester 1.
- rsp_valid  out  1  response stage holds a result.
- rsp_ready  in  1  consumer takes the result when high with rsp_valid.
- rsp_id  out  1  index of the requester that produced the result.
- rsp_sum  out  WIDTH  result, modulo 2^WIDTH.
- rsp_ovf  out  1  signed overflow of that result.
- ovf_clr  in  1  synchronous clear of ovf_count.
- ovf_count  out  CNT_W  saturating count of accepted operations with overflow.

## Operation
- Datapath: B' = B XOR {WIDTH{op}}, carry-in = op, S = A + B' + op. Overflow = carry into MSB XOR carry out of MSB.
- Response stage states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- Accept enable: acc_en = EMPTY or (FULL and rsp_ready).
- Arbitration, evaluated only when acc_en = 1:
  - Exactly one requester valid: grant that requester.
  - Both valid: grant the requester indicated by priority pointer prio.
- reqN_ready = acc_en and grant==N, combinational. At most one ready is high per cycle.
- No requester is granted while FULL and rsp_ready = 0. Both readies are low.
- On acceptance:
  - Compute with the granted operands in the same cycle.
  - Register rsp_sum, rsp_ovf and rsp_id; state becomes FULL.
  - prio toggles to the non-granted requester, only when both were valid. A grant to the sole valid requester leaves prio unchanged.
- FULL with rsp_ready = 1 and no acceptance: state becomes EMPTY. rsp_sum/rsp_ovf/rsp_id hold their last value.
- FULL with rsp_ready = 1 and an acceptance in the same cycle: state stays FULL with the new result. This allows one operation per cycle sustained.
- Response outputs are stable while rsp_valid = 1 and rsp_ready = 0.
- ovf_count:
  - Increments by 1 on an acceptance whose overflow = 1, saturating at 2^CNT_W−1.
  - ovf_clr has priority: clear and overflow-acceptance in the same cycle gives 0.
- Requester inputs are sampled only in the accept cycle. Changing operands while valid and not ready is legal and has no effect.

## Timing
- Reset values: rsp_valid=0, rsp_sum=0, rsp_ovf=0, rsp_id=0, ovf_count=0, prio=0 (requester 0 wins the first contention).
- Reset asserted mid-operation discards the held response and clears all state immediately. No response is emitted for an operation in flight.
- Latency: operation accepted at edge k → rsp_valid=1 with its result from edge k onward (visible in cycle k+1).
- Throughput: 1 operation/cycle while rsp_ready stays high.
- Combinational paths:
  - rsp_ready → reqN_ready.
  - reqN_valid → reqM_ready.
  - No combinational path from request operands to any output.

## Structure
- Package addsub_pkg holds:
  - WIDTH = 15 and CNT_W = 8 defaults.
  - The op_e typedef (OP_ADD=0, OP_SUB=1).
  - The response struct {id, sum, ovf}.
- Sub-module addsub15: combinational WIDTH-bit ripple add/subtract with overflow. Ports A, B, op → S, V.
- Instantiated once, fed through the grant mux.
- Arbiter, response register and counter live in addsub_arbiter.

## Test plan
- Reset, then req0 valid with a=5, b=3, op=SUB; rsp_ready=1 → req0_ready high in the first cycle; next cycle rsp_valid=1, rsp_sum=2, rsp_ovf=0, rsp_id=0.
- req1: a=16383 (0x3FFF), b=1, ADD → rsp_sum=0x4000, rsp_ovf=1, ovf_count=1. Then a=0x4000 (−16384), b=1, SUB → 0x3FFF, ovf=1, ovf_count=2.
- Both requesters valid continuously, rsp_ready=1 → grants alternate 0,1,0,1 on consecutive cycles; rsp_id follows the same sequence one cycle later.
- rsp_ready=0 for 5 cycles while FULL → both readies low, response held unchanged. Raise rsp_ready with req0 valid → old result consumed and new one loaded in the same edge; rsp_valid stays 1.
- 300 overflowing operations (0x3FFF+1) → ovf_count saturates at 255. ovf_clr asserted together with an overflowing acceptance → ovf_count=0.
- Assert rst_n low while FULL with rsp_ready=0 → rsp_valid, rsp_sum, ovf_count and prio return to 0 asynchronously. The first contention after reset is granted to requester 0.
